// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: round-robin arbiter sharing the register-file write port between
// ALU and load writeback, with a per-register pending-write scoreboard for hazard stalls.
module rf_writeback_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_data,
    output logic                 a_ready,
    input  logic                 m_valid,
    input  logic [ADDR_W-1:0]    m_addr,
    input  logic [DATA_W-1:0]    m_data,
    output logic                 m_ready,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic                 rsv_ready,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 unrsv_err,
    output logic [CNT_W-1:0]     conflict_cnt
);
    localparam int NREGS = 2**ADDR_W;

    logic             ptrM;
    logic             bothValid;
    logic [NREGS-1:0] setMask;
    logic [NREGS-1:0] clrMask;

    always_comb begin
        bothValid = a_valid & m_valid;
        a_ready   = a_valid & (~m_valid | ~ptrM);
        m_ready   = m_valid & (~a_valid | ptrM);
        rsv_ready = ~busy[rsv_addr];
        setMask   = (rsv_valid & rsv_ready) ? NREGS'(1) << rsv_addr : '0;
        clrMask   = rf_we ? NREGS'(1) << rf_waddr : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptrM         <= 1'b0;
            busy         <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            unrsv_err    <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            rf_we <= a_ready | m_ready;
            if (a_ready | m_ready) begin
                rf_waddr <= a_ready ? a_addr : m_addr;
                rf_wdata <= a_ready ? a_data : m_data;
            end
            if (bothValid) ptrM <= ~ptrM;
            // set is applied after clear so a same-cycle reserve keeps the bit pending
            busy <= (busy & ~clrMask) | setMask;
            if (rf_we & ~busy[rf_waddr]) unrsv_err <= 1'b1;
            if (bothValid && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed-vector bench for the writeback arbiter and scoreboard.
module tb_rf_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0, m_valid = 1'b0, rsv_valid = 1'b0;
    logic [3:0]  a_addr = '0, m_addr = '0, rsv_addr = '0;
    logic [31:0] a_data = '0, m_data = '0;
    logic        a_ready, m_ready, rsv_ready, rf_we, unrsv_err;
    logic [15:0] busy, conflict_cnt;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rf_writeback_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .unrsv_err(unrsv_err), .conflict_cnt(conflict_cnt)
    );

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        a_valid = 0; m_valid = 0; rsv_valid = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic reserve(input logic [3:0] r);
        @(negedge clk);
        rsv_valid = 1; rsv_addr = r;
        @(posedge clk); #1;
        rsv_valid = 0;
    endtask

    task automatic test_reset();
        applyReset();
        #1;
        compared++;
        if ({rf_we, rf_waddr, rf_wdata, busy, unrsv_err, conflict_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: we=%0b waddr=%0d wdata=%0d busy=%h err=%0b cnt=%0d, expected all zero",
                     rf_we, rf_waddr, rf_wdata, busy, unrsv_err, conflict_cnt);
        end
    endtask

    task automatic test_basic();
        applyReset();
        @(negedge clk);
        rsv_valid = 1; rsv_addr = 5; #1;
        compared++;
        if (rsv_ready !== 1'b1) begin mismatched++; $display("FAIL basic_rsv_ready: got %0b want 1", rsv_ready); end
        @(posedge clk); #1;
        compared++;
        if (busy !== 16'h0020) begin mismatched++; $display("FAIL basic_busy_set: got %h want 0020", busy); end
        @(negedge clk);
        rsv_valid = 0; a_valid = 1; a_addr = 5; a_data = 100; #1;
        compared++;
        if (a_ready !== 1'b1) begin mismatched++; $display("FAIL basic_a_ready: got %0b want 1", a_ready); end
        @(posedge clk); #1;
        compared++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd5, 32'd100}) begin
            mismatched++; $display("FAIL basic_write: got we=%0b addr=%0d data=%0d want 1/5/100", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        a_valid = 0;
        @(posedge clk); #1;
        compared++;
        if ({busy, unrsv_err, rf_we, rf_waddr, rf_wdata} !== {16'h0, 1'b0, 1'b0, 4'd5, 32'd100}) begin
            mismatched++;
            $display("FAIL basic_after: got busy=%h err=%0b we=%0b addr=%0d data=%0d want 0000/0/0/5/100",
                     busy, unrsv_err, rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_conflict();
        applyReset();
        reserve(3);
        reserve(7);
        @(negedge clk);
        a_valid = 1; a_addr = 3; a_data = 30; m_valid = 1; m_addr = 7; m_data = 70; #1;
        compared++;
        if ({a_ready, m_ready} !== 2'b10) begin mismatched++; $display("FAIL conflict_grant1: got a=%0b m=%0b want a=1 m=0", a_ready, m_ready); end
        @(posedge clk); #1;
        compared++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 32'd30}) begin
            mismatched++; $display("FAIL conflict_write1: got we=%0b addr=%0d data=%0d want 1/3/30", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        a_valid = 0; #1;
        compared++;
        if (m_ready !== 1'b1) begin mismatched++; $display("FAIL conflict_grant2: got m_ready=%0b want 1", m_ready); end
        @(posedge clk); #1;
        compared++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd7, 32'd70}) begin
            mismatched++; $display("FAIL conflict_write2: got we=%0b addr=%0d data=%0d want 1/7/70", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        m_valid = 0;
        @(posedge clk); #1;
        compared++;
        if ({conflict_cnt, busy, unrsv_err} !== {16'd1, 16'h0, 1'b0}) begin
            mismatched++; $display("FAIL conflict_end: got cnt=%0d busy=%h err=%0b want 1/0000/0", conflict_cnt, busy, unrsv_err);
        end
    endtask

    task automatic test_alternate();
        applyReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_valid = 1; a_addr = 4'(i); a_data = 32'h100 + i;
            m_valid = 1; m_addr = 4'(8 + i); m_data = 32'h200 + i; #1;
            compared++;
            if ({a_ready, m_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                mismatched++; $display("FAIL alternate_grant%0d: got a=%0b m=%0b", i, a_ready, m_ready);
            end
            @(posedge clk); #1;
            compared++;
            if (rf_waddr !== ((i % 2 == 0) ? 4'(i) : 4'(8 + i))) begin
                mismatched++; $display("FAIL alternate_waddr%0d: got %0d want %0d", i, rf_waddr, (i % 2 == 0) ? i : 8 + i);
            end
        end
        @(negedge clk);
        a_valid = 0; m_valid = 0; #1;
        compared++;
        if (conflict_cnt !== 16'd4) begin mismatched++; $display("FAIL alternate_cnt: got %0d want 4", conflict_cnt); end
    endtask

    task automatic test_same_cycle();
        applyReset();
        reserve(2);
        @(negedge clk);
        a_valid = 1; a_addr = 2; a_data = 22;
        @(negedge clk);
        a_valid = 0; rsv_valid = 1; rsv_addr = 2; #1;
        compared++;
        if ({rf_we, rsv_ready} !== 2'b10) begin mismatched++; $display("FAIL same_rsv_blocked: got we=%0b rsv_ready=%0b want 1/0", rf_we, rsv_ready); end
        @(posedge clk); #1;
        compared++;
        if (busy !== 16'h0) begin mismatched++; $display("FAIL same_busy_clear: got %h want 0000", busy); end
        @(negedge clk); #1;
        compared++;
        if (rsv_ready !== 1'b1) begin mismatched++; $display("FAIL same_rsv_ready: got %0b want 1", rsv_ready); end
        @(posedge clk); #1;
        compared++;
        if ({busy, unrsv_err} !== {16'h0004, 1'b0}) begin mismatched++; $display("FAIL same_busy_reset: got busy=%h err=%0b want 0004/0", busy, unrsv_err); end
        rsv_valid = 0;
    endtask

    task automatic test_unreserved();
        applyReset();
        @(negedge clk);
        m_valid = 1; m_addr = 9; m_data = 99;
        @(posedge clk); #1;
        compared++;
        if ({rf_we, rf_waddr, unrsv_err} !== {1'b1, 4'd9, 1'b0}) begin
            mismatched++; $display("FAIL unrsv_write: got we=%0b addr=%0d err=%0b want 1/9/0", rf_we, rf_waddr, unrsv_err);
        end
        @(negedge clk);
        m_valid = 0;
        @(posedge clk); #1;
        compared++;
        if ({unrsv_err, busy} !== {1'b1, 16'h0}) begin mismatched++; $display("FAIL unrsv_err_set: got err=%0b busy=%h want 1/0000", unrsv_err, busy); end
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (unrsv_err !== 1'b1) begin mismatched++; $display("FAIL unrsv_err_sticky: got %0b want 1", unrsv_err); end
    endtask

    task automatic test_reset_inflight();
        applyReset();
        reserve(4);
        @(negedge clk);
        a_valid = 1; a_addr = 4; a_data = 44; m_valid = 1; m_addr = 6; m_data = 66;
        @(posedge clk); #1;
        a_valid = 0; m_valid = 0;
        compared++;
        if (rf_we !== 1'b1) begin mismatched++; $display("FAIL inflight_pending: got we=%0b want 1", rf_we); end
        reset = 1; #1;
        compared++;
        if ({rf_we, rf_waddr, rf_wdata, busy, conflict_cnt} !== '0) begin
            mismatched++; $display("FAIL inflight_reset: got we=%0b addr=%0d data=%0d busy=%h cnt=%0d want zeros",
                                   rf_we, rf_waddr, rf_wdata, busy, conflict_cnt);
        end
        @(negedge clk);
        reset = 0;
        a_valid = 1; a_addr = 1; a_data = 11; m_valid = 1; m_addr = 2; m_data = 12; #1;
        compared++;
        if ({a_ready, m_ready} !== 2'b10) begin mismatched++; $display("FAIL inflight_ptr: got a=%0b m=%0b want a=1 m=0", a_ready, m_ready); end
        @(negedge clk);
        a_valid = 0; m_valid = 0;
    endtask

    task automatic test_saturation();
        applyReset();
        @(negedge clk);
        a_valid = 1; m_valid = 1; a_addr = 1; m_addr = 2;
        repeat (65537) @(posedge clk);
        #1;
        compared++;
        if (conflict_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL cnt_saturate: got %h want ffff", conflict_cnt); end
        a_valid = 0; m_valid = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conflict();
        test_alternate();
        test_same_cycle();
        test_unreserved();
        test_reset_inflight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
